present_iter: RTL



---
 rtl/present_iter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/present_iter.sv
// Iterative PRESENT-64 encryption core.
// 80/128-bit key, configurable round count and S-box parallelism.
module present_iter #(
   parameter int KEY_WIDTH = 80,
   parameter int ROUNDS    = 31,
   parameter int SBOX_PAR  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [63:0]          x,
   input  logic [KEY_WIDTH-1:0] k,
   output logic                 busy,
   output logic                 done,
   output logic [63:0]          r
);

   localparam int C  = 16 / SBOX_PAR;
   localparam int NW = (C > 1) ? $clog2(C) : 1;
   localparam int IP = (KEY_WIDTH == 80) ? 15 : 62;
   localparam logic [63:0] SBT = 64'h2174_8FE3_DA09_B65C;

   if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_kw
      $error("present_iter: KEY_WIDTH must be 80 or 128");
   end
   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_iter: ROUNDS must be 1..31");
   end
   if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 ||
         SBOX_PAR == 8 || SBOX_PAR == 16)) begin : g_bad_par
      $error("present_iter: SBOX_PAR must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [63:0]          s;
   logic [KEY_WIDTH-1:0] kr;
   logic [KEY_WIDTH-1:0] kn;
   logic [4:0]           i;
   logic [NW-1:0]        n;
   logic                 last;
   logic [63:0]          rk;
   logic [63:0]          t;
   logic [63:0]          u;
   logic [63:0]          p;
   logic [3:0]           idx;

   function automatic logic [3:0] sbox(input logic [3:0] a);
      return SBT[{a, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] perm(input logic [63:0] a);
      logic [63:0] y;
      y = '0;
      y[63] = a[63];
      for (int j = 0; j < 63; j++) y[(16 * j) % 63] = a[j];
      return y;
   endfunction

   assign rk   = kr[KEY_WIDTH-1 -: 64];
   assign last = (n == NW'(C - 1));

   // Round datapath: key add on first sub-cycle, partial S-box layer, permutation.
   always_comb begin
      idx = '0;
      t   = (n == '0) ? (s ^ rk) : s;
      u   = t;
      for (int q = 0; q < SBOX_PAR; q++) begin
         idx = 4'(int'(n) * SBOX_PAR + q);
         u[{idx, 2'b00} +: 4] = sbox(t[{idx, 2'b00} +: 4]);
      end
      p = perm(u);
   end

   // Key schedule step: rotate left 61, S-box top nibble(s), mix in counter.
   always_comb begin
      kn = {kr[KEY_WIDTH-62:0], kr[KEY_WIDTH-1:KEY_WIDTH-61]};
      kn[KEY_WIDTH-1 -: 4] = sbox(kn[KEY_WIDTH-1 -: 4]);
      if (KEY_WIDTH == 128) begin
         kn[KEY_WIDTH-5 -: 4] = sbox(kn[KEY_WIDTH-5 -: 4]);
      end
      kn[IP +: 5] = kn[IP +: 5] ^ i;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req) state_nxt = ROUND;
         ROUND:   if (last && i == 5'(ROUNDS)) state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Cipher state, key register, round counter and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s    <= '0;
         kr   <= '0;
         i    <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         r    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  s    <= x;
                  kr   <= k;
                  i    <= 5'd1;
                  busy <= 1'b1;
               end
            end
            ROUND: begin
               if (last) begin
                  s  <= p;
                  kr <= kn;
                  if (i != 5'h1F) i <= i + 5'd1;
               end else begin
                  s <= u;
               end
            end
            FINAL: begin
               r    <= s ^ rk;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   if (C > 1) begin : g_nib
      // Nibble-group counter within a round.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                  n <= '0;
         else if (state != ROUND)  n <= '0;
         else if (last)            n <= '0;
         else                      n <= n + NW'(1);
      end
   end else begin : g_nonib
      assign n = '0;
   end

endmodule
